// File: rtl/npc_multicycle_ctrl.sv
// Multi-cycle sequencer for the npc core: owns PC, IR, imem/dmem handshakes, timeout and instret.
// Latency: 4 cycles per non-memory instruction, 6 per load/store with zero-wait memories.
// Backpressure: waits in FETCH/MEM for ready and WAIT_I/WAIT_D for response; stalls past MEM_TIMEOUT go to ERR.
module npc_multicycle_ctrl #(
    parameter int unsigned         XLEN        = 64,
    parameter logic [XLEN-1:0]     RESET_PC    = 64'h8000_0000,
    parameter int unsigned         MEM_TIMEOUT = 255,
    parameter int unsigned         CNT_W       = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [XLEN-1:0]  imem_addr,
    input  logic             imem_resp_valid,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      inst_o,
    output logic [XLEN-1:0]  pc_o,
    input  logic             dp_is_mem,
    input  logic             dp_mem_we,
    input  logic [XLEN-1:0]  dp_mem_addr,
    input  logic [XLEN-1:0]  dp_mem_wdata,
    input  logic             dp_jump_flag,
    input  logic [XLEN-1:0]  dp_jump_addr,
    output logic             dmem_req_valid,
    input  logic             dmem_req_ready,
    output logic             dmem_we,
    output logic [XLEN-1:0]  dmem_addr,
    output logic [XLEN-1:0]  dmem_wdata,
    input  logic             dmem_resp_valid,
    input  logic [XLEN-1:0]  dmem_rdata,
    output logic [XLEN-1:0]  mem_rdata_o,
    output logic             reg_we_en,
    output logic             csr_we_en,
    output logic             retire_o,
    output logic [CNT_W-1:0] instret_o,
    output logic             bus_err_o,
    output logic [2:0]       state_o
);

    localparam logic [2:0] S_BOOT   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_WAIT_I = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WAIT_D = 3'd5;
    localparam logic [2:0] S_WB     = 3'd6;
    localparam logic [2:0] S_ERR    = 3'd7;

    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    logic [2:0]       state_q,   state_d;
    logic [XLEN-1:0]  pc_q,      pc_d;
    logic [31:0]      ir_q,      ir_d;
    logic             dwe_q,     dwe_d;
    logic [XLEN-1:0]  daddr_q,   daddr_d;
    logic [XLEN-1:0]  dwdata_q,  dwdata_d;
    logic [XLEN-1:0]  mrdata_q,  mrdata_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             err_q,     err_d;
    logic [31:0]      tmo_q,     tmo_d;
    // Misaligned-redirect verdict captured in EXEC. The datapath is combinational
    // from ir/pc, which do not change until WB, so the EXEC value is the WB value;
    // registering it keeps the commit strobes a pure decode of flops.
    logic             badj_q,    badj_d;

    logic wait_st;
    logic tmo_hit;

    // Next-state, datapath latches, timeout counter and commit bookkeeping.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        dwe_d     = dwe_q;
        daddr_d   = daddr_q;
        dwdata_d  = dwdata_q;
        mrdata_d  = mrdata_q;
        instret_d = instret_q;
        err_d     = err_q;
        badj_d    = badj_q;

        wait_st = (state_q == S_FETCH) || (state_q == S_WAIT_I) ||
                  (state_q == S_MEM)   || (state_q == S_WAIT_D);
        // The counter holds cycles already spent here; this cycle is the MEM_TIMEOUT-th.
        tmo_hit = (MEM_TIMEOUT != 0) && wait_st && (tmo_q == MEM_TIMEOUT - 32'd1);

        case (state_q)
            S_BOOT: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (imem_req_ready) begin
                    state_d = S_WAIT_I;
                end else if (tmo_hit) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                end
            end
            S_WAIT_I: begin
                if (imem_resp_valid) begin
                    ir_d    = imem_rdata;
                    state_d = S_EXEC;
                end else if (tmo_hit) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                end
            end
            S_EXEC: begin
                badj_d = dp_jump_flag && (dp_jump_addr[1:0] != 2'b00);
                if (dp_is_mem) begin
                    dwe_d    = dp_mem_we;
                    daddr_d  = dp_mem_addr;
                    dwdata_d = dp_mem_wdata;
                    state_d  = S_MEM;
                end else begin
                    state_d  = S_WB;
                end
            end
            S_MEM: begin
                if (dmem_req_ready) begin
                    state_d = S_WAIT_D;
                end else if (tmo_hit) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                end
            end
            S_WAIT_D: begin
                if (dmem_resp_valid) begin
                    // A store response is only an acknowledge; keep the last load data.
                    if (!dwe_q) begin
                        mrdata_d = dmem_rdata;
                    end
                    state_d = S_WB;
                end else if (tmo_hit) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                end
            end
            S_WB: begin
                if (badj_q) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                end else begin
                    instret_d = instret_q + CNT_W'(1);
                    pc_d      = dp_jump_flag ? dp_jump_addr : pc_q + XLEN'(4);
                    state_d   = S_FETCH;
                end
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                state_d = S_ERR;
            end
        endcase

        if (state_d != state_q) begin
            tmo_d = 32'd0;
        end else if (wait_st) begin
            tmo_d = tmo_q + 32'd1;
        end else begin
            tmo_d = tmo_q;
        end
    end

    // State and datapath registers; reset aborts any outstanding handshake at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_BOOT;
            pc_q      <= RESET_PC;
            ir_q      <= INST_NOP;
            dwe_q     <= 1'b0;
            daddr_q   <= '0;
            dwdata_q  <= '0;
            mrdata_q  <= '0;
            instret_q <= '0;
            err_q     <= 1'b0;
            tmo_q     <= '0;
            badj_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            dwe_q     <= dwe_d;
            daddr_q   <= daddr_d;
            dwdata_q  <= dwdata_d;
            mrdata_q  <= mrdata_d;
            instret_q <= instret_d;
            err_q     <= err_d;
            tmo_q     <= tmo_d;
            badj_q    <= badj_d;
        end
    end

    // Requests and commit strobes decode only registered state.
    always_comb begin
        imem_req_valid = (state_q == S_FETCH);
        dmem_req_valid = (state_q == S_MEM);
        retire_o       = (state_q == S_WB) && !badj_q;
        reg_we_en      = retire_o;
        csr_we_en      = retire_o;
    end

    assign imem_addr   = pc_q;
    assign pc_o        = pc_q;
    assign inst_o      = ir_q;
    assign dmem_we     = dwe_q;
    assign dmem_addr   = daddr_q;
    assign dmem_wdata  = dwdata_q;
    assign mem_rdata_o = mrdata_q;
    assign instret_o   = instret_q;
    assign bus_err_o   = err_q;
    assign state_o     = state_q;

endmodule

// File: doc/npc_multicycle_ctrl.md
# npc_multicycle_ctrl

Multi-cycle sequencing controller for the next-generation npc core, replacing the single-cycle top's implicit one-instruction-per-clock timing. It owns the PC, instruction register, instruction/data memory valid-ready handshakes, memory timeout detection and retired-instruction counting. The existing IF/ID/EX/MEM/GEN_REGS/CSR_REGS datapath stays combinational around it. The controller gates register-file and CSR writes to a single commit cycle per instruction, so memories with arbitrary latency can be attached.

## Interface
- XLEN, 64, PC/address/data width
- RESET_PC, 64'h8000_0000, PC value loaded at reset
- MEM_TIMEOUT, 255, max cycles waited in any handshake state; 0 disables the timeout
- CNT_W, 64, width of instret_o
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  reset, asynchronous and active-low
- imem_req_valid  out  1  fetch request
- imem_req_ready  in  1  instruction memory accepts request
- imem_addr  out  XLEN  fetch address (= pc)
- imem_resp_valid  in  1  fetch data valid
- imem_rdata  in  32  fetched instruction
- inst_o  out  32  instruction register, to ID
- pc_o  out  XLEN  PC of inst_o, to ID/EX
- dp_is_mem  in  1  EX: instruction accesses memory
- dp_mem_we  in  1  EX: store (1) / load (0)
- dp_mem_addr  in  XLEN  EX: memory address
- dp_mem_wdata  in  XLEN  EX: store data
- dp_jump_flag  in  1  EX: redirect
- dp_jump_addr  in  XLEN  EX: redirect target
- dmem_req_valid  out  1  data request
- dmem_req_ready  in  1  data memory accepts request
- dmem_we  out  1  latched dp_mem_we
- dmem_addr  out  XLEN  latched dp_mem_addr
- dmem_wdata  out  XLEN  latched dp_mem_wdata
- dmem_resp_valid  in  1  load data valid / store acknowledge
- dmem_rdata  in  XLEN  load data
- mem_rdata_o  out  XLEN  latched load data, to MEM stage
- reg_we_en  out  1  commit strobe ANDed with the GEN_REGS write enable
- csr_we_en  out  1  commit strobe ANDed with the CSR_REGS write enable
- retire_o  out  1  one-cycle pulse per retired instruction
- instret_o  out  CNT_W  retired-instruction count
- bus_err_o  out  1  sticky error flag
- state_o  out  3  current state, for debug

## Operation
- State encoding: BOOT=0, FETCH=1, WAIT_I=2, EXEC=3, MEM=4, WAIT_D=5, WB=6, ERR=7.
- **BOOT:** entered on reset; lasts one cycle, then FETCH.
- **FETCH:** imem_req_valid=1 and imem_addr=pc. If imem_req_ready, go to WAIT_I.
- **WAIT_I:** when imem_resp_valid, latch ir <= imem_rdata and go to EXEC. Responses are sampled only in WAIT_I and WAIT_D.
- **EXEC:** one cycle; the datapath evaluates from ir/pc.
  - If dp_is_mem: latch dmem_we/addr/wdata and go to MEM.
  - Otherwise go to WB.
- **MEM:** dmem_req_valid=1. If dmem_req_ready, go to WAIT_D.
- **WAIT_D:** when dmem_resp_valid, latch mem_rdata_o <= dmem_rdata (loads only; stores leave it unchanged) and go to WB.
- **WB:** one cycle.
  - reg_we_en=1, csr_we_en=1, retire_o=1, instret_o += 1 (wraps modulo 2^CNT_W).
  - pc <= dp_jump_flag ? dp_jump_addr : pc+4 (wraps modulo 2^XLEN).
  - Then go to FETCH.
- **Misaligned redirect:** in WB with dp_jump_flag=1 and dp_jump_addr[1:0]!=0, no strobes assert, pc and instret_o hold, bus_err_o<=1, and the next state is ERR.
- **Timeout:** a counter clears on every state transition and increments each cycle spent in FETCH, WAIT_I, MEM or WAIT_D. If it reaches MEM_TIMEOUT in any of those states (MEM_TIMEOUT!=0), the next state is ERR and bus_err_o<=1. A handshake completing in the same cycle as the timeout wins over the timeout.
- **ERR:** absorbing. All request and strobe outputs are 0; leave only via rst_n.
- **Handshake rule:** once asserted, valid and address/data stay stable until ready.

## Timing
- Reset values:
  - state=BOOT, pc=RESET_PC, ir=32'h0000_0013 (nop).
  - mem_rdata_o=0, dmem_we/addr/wdata=0, instret_o=0, bus_err_o=0.
  - All valid and strobe outputs 0.
- Reset mid-operation aborts any outstanding request immediately. Responses arriving after reset are ignored because they only count in WAIT states.
- imem_req_valid, dmem_req_valid, reg_we_en, csr_we_en and retire_o are decoded from the registered state, with no input-to-output combinational path.
- With zero-wait memory (ready in the request cycle, response the next cycle):
  - Non-memory instruction: 4 cycles, FETCH→WAIT_I→EXEC→WB.
  - Load/store: 6 cycles.
- The first FETCH occurs in the 2nd cycle after rst_n deasserts.
- Each cycle ready is low in FETCH/MEM, or the response is absent in WAIT_I/WAIT_D, adds one cycle.

## Test plan
- **Reset:** rst_n low mid-WAIT_D → next edge state_o=0, all strobes 0, pc_o=64'h8000_0000, instret_o=0.
- **ALU op, zero-wait:** addi fetched → retire_o pulses on cycle 5 after reset release, pc_o=64'h8000_0004, reg_we_en high exactly 1 cycle.
- **Load with stalls:** dmem_req_ready held low 3 cycles, response 2 cycles later, dmem_rdata=64'hDEAD_BEEF → mem_rdata_o=64'hDEAD_BEEF in WB; dmem_addr stable throughout MEM.
- **Jump:** dp_jump_flag=1, dp_jump_addr=64'h8000_0100 → next imem_addr=64'h8000_0100. With dp_jump_addr=64'h8000_0102 instead → bus_err_o=1, state_o=7, no retire.
- **Timeout:** MEM_TIMEOUT=4, imem_req_ready held low → ERR entered after 4 FETCH cycles; ready arriving exactly on the 4th cycle → WAIT_I, no error.
- **Counter wrap:** CNT_W=4, 16 instructions retired → instret_o returns to 0 and pc advances normally.
